// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl: runtime sequencer for a Gowin rPLL in dynamic-divider mode.
// Drives the divider selects from a mode table and sequences reset/lock.
// Ports:
//   clkin, reset         reference clock, async active-high reset
//   mode_req, mode_sel   request level, requested table entry
//   busy, done, status   sequencing flag, completion pulse, result code
//   cur_mode, lock_lost  applied mode, sticky lock-drop flag
//   pll_lock, pll_reset  rPLL LOCK (async) in, rPLL RESET out
//   pll_idsel/fbdsel/odsel  rPLL divider selects
//   rst_out              reset for logic clocked by the PLL output
module pll_dyn_ctrl #(
    parameter int          NUM_MODES     = 4,
    parameter logic [1:0]  DEFAULT_MODE  = 2'd0,
    parameter logic [23:0] IDSEL_TABLE   = 24'h000000,
    parameter logic [23:0] FBDSEL_TABLE  = 24'h000000,
    parameter logic [23:0] ODSEL_TABLE   = 24'h000000,
    parameter int          RST_CYCLES    = 16,
    parameter int          LOCK_TIMEOUT  = 27000,
    parameter int          STABLE_CYCLES = 256,
    parameter int          MAX_RETRY     = 3
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       mode_req,
    input  logic [1:0] mode_sel,
    output logic       busy,
    output logic       done,
    output logic [1:0] status,
    output logic [1:0] cur_mode,
    output logic       lock_lost,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       rst_out
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int AW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [RW-1:0] LP_RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] LP_TO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] LP_TO_MAX   = TW'(LOCK_TIMEOUT);
    localparam logic [SW-1:0] LP_STB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] LP_STB_MAX  = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] LP_STB_ONE  = SW'(1);
    localparam logic [AW-1:0] LP_ATT_MAX  = AW'(MAX_RETRY);
    localparam logic [2:0]    LP_NMODES   = 3'(NUM_MODES);

    typedef enum logic [2:0] {
        S_RST,
        S_WAIT,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    function automatic logic [5:0] f_sel(
        input logic [23:0] t,
        input logic [1:0]  m
    );
        logic [5:0] v;
        case (m)
            2'd0:    v = t[5:0];
            2'd1:    v = t[11:6];
            2'd2:    v = t[17:12];
            default: v = t[23:18];
        endcase
        return v;
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [RW-1:0] r_rst_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [SW-1:0] r_stb_cnt;
    logic [AW-1:0] r_att;
    logic          r_lock_s1;
    logic          r_lock_s2;
    logic          r_req;
    logic          r_busy;
    logic          r_done;
    logic [1:0]    r_status;
    logic [1:0]    r_cur_mode;
    logic          r_lock_lost;
    logic          r_pll_reset;
    logic          r_rst_out;
    logic [5:0]    r_idsel;
    logic [5:0]    r_fbdsel;
    logic [5:0]    r_odsel;

    logic       w_lock_s;
    logic       w_accept;
    logic       w_bad_mode;
    logic       w_load;
    logic [1:0] w_mode_nxt;
    logic       w_req_ok;
    logic       w_req_bad;
    logic       w_loss;
    logic       w_retry;
    logic       w_in_lock;
    logic       w_nxt_lock;
    logic       w_nxt_idle;
    logic       w_idle;

    assign w_lock_s   = r_lock_s2;
    assign w_idle     = (r_state == S_RUN) || (r_state == S_FAIL);
    assign w_accept   = mode_req && w_idle;
    assign w_bad_mode = ({1'b0, mode_sel} >= LP_NMODES);
    assign w_in_lock  = (r_state == S_WAIT) || (r_state == S_STABLE);
    assign w_nxt_lock = (w_state_nxt == S_WAIT) || (w_state_nxt == S_STABLE);
    assign w_nxt_idle = (w_state_nxt == S_RUN) || (w_state_nxt == S_FAIL);

    // Two-flop synchroniser for the asynchronous LOCK output
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_lock_s1 <= 1'b0;
            r_lock_s2 <= 1'b0;
        end else begin
            r_lock_s1 <= pll_lock;
            r_lock_s2 <= r_lock_s1;
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_mode_nxt  = r_cur_mode;
        w_req_ok    = 1'b0;
        w_req_bad   = 1'b0;
        w_loss      = 1'b0;
        w_retry     = 1'b0;
        case (r_state)
            S_RST: begin
                if (r_rst_cnt == LP_RST_LAST) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT, S_STABLE: begin
                // A completed lock filter wins over a same-cycle timeout
                if (w_lock_s && r_state == S_WAIT && STABLE_CYCLES <= 1) begin
                    w_state_nxt = S_RUN;
                end else if (w_lock_s && r_state == S_STABLE &&
                             r_stb_cnt == LP_STB_LAST) begin
                    w_state_nxt = S_RUN;
                end else if (r_to_cnt == LP_TO_LAST) begin
                    if (r_att < LP_ATT_MAX) begin
                        w_retry     = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = S_RST;
                    end else begin
                        w_state_nxt = S_FAIL;
                    end
                end else if (r_state == S_WAIT && w_lock_s) begin
                    w_state_nxt = S_STABLE;
                end else if (r_state == S_STABLE && !w_lock_s) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_RUN, S_FAIL: begin
                // A request takes priority over a same-cycle lock drop
                if (w_accept) begin
                    if (w_bad_mode) begin
                        w_req_bad = 1'b1;
                    end else begin
                        w_req_ok    = 1'b1;
                        w_load      = 1'b1;
                        w_mode_nxt  = mode_sel;
                        w_state_nxt = S_RST;
                    end
                end else if (r_state == S_RUN && !w_lock_s) begin
                    w_loss      = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = S_RST;
                end
            end
            default: begin
                w_state_nxt = S_RST;
            end
        endcase
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_rst_cnt   <= '0;
            r_to_cnt    <= '0;
            r_stb_cnt   <= '0;
            r_att       <= '0;
            r_req       <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_status    <= 2'd0;
            r_cur_mode  <= DEFAULT_MODE;
            r_lock_lost <= 1'b0;
            r_pll_reset <= 1'b1;
            r_rst_out   <= 1'b1;
            r_idsel     <= f_sel(IDSEL_TABLE, DEFAULT_MODE);
            r_fbdsel    <= f_sel(FBDSEL_TABLE, DEFAULT_MODE);
            r_odsel     <= f_sel(ODSEL_TABLE, DEFAULT_MODE);
        end else begin
            if (r_state == S_RST && w_state_nxt == S_RST) begin
                if (r_rst_cnt != LP_RST_LAST) begin
                    r_rst_cnt <= r_rst_cnt + 1'b1;
                end
            end else begin
                r_rst_cnt <= '0;
            end

            // Timeout spans WAIT and STABLE, surviving STABLE->WAIT
            if (w_in_lock && w_nxt_lock) begin
                if (r_to_cnt != LP_TO_MAX) begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end

            // The WAIT cycle that saw lock counts as the first good cycle
            if (r_state == S_WAIT && w_state_nxt == S_STABLE) begin
                r_stb_cnt <= LP_STB_ONE;
            end else if (r_state == S_STABLE && w_state_nxt == S_STABLE) begin
                if (r_stb_cnt != LP_STB_MAX) begin
                    r_stb_cnt <= r_stb_cnt + 1'b1;
                end
            end else begin
                r_stb_cnt <= '0;
            end

            if (w_req_ok || w_loss) begin
                r_att <= '0;
            end else if (w_retry) begin
                r_att <= r_att + 1'b1;
            end

            if (w_req_ok) begin
                r_req <= 1'b1;
            end else if (w_nxt_idle && !w_idle) begin
                r_req <= 1'b0;
            end

            r_done <= 1'b0;
            if (w_req_bad) begin
                r_done   <= 1'b1;
                r_status <= 2'd1;
            end else if (r_req && !w_idle && w_state_nxt == S_RUN) begin
                r_done   <= 1'b1;
                r_status <= 2'd0;
            end else if (r_req && !w_idle && w_state_nxt == S_FAIL) begin
                r_done   <= 1'b1;
                r_status <= 2'd2;
            end

            if (w_req_ok) begin
                r_lock_lost <= 1'b0;
            end else if (w_loss) begin
                r_lock_lost <= 1'b1;
            end

            if (w_load) begin
                r_cur_mode <= w_mode_nxt;
                r_idsel    <= f_sel(IDSEL_TABLE, w_mode_nxt);
                r_fbdsel   <= f_sel(FBDSEL_TABLE, w_mode_nxt);
                r_odsel    <= f_sel(ODSEL_TABLE, w_mode_nxt);
            end

            r_busy      <= !w_nxt_idle;
            r_pll_reset <= (w_state_nxt == S_RST) || (w_state_nxt == S_FAIL);
            r_rst_out   <= (w_state_nxt != S_RUN);
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign status     = r_status;
    assign cur_mode   = r_cur_mode;
    assign lock_lost  = r_lock_lost;
    assign pll_reset  = r_pll_reset;
    assign pll_idsel  = r_idsel;
    assign pll_fbdsel = r_fbdsel;
    assign pll_odsel  = r_odsel;
    assign rst_out    = r_rst_out;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// tb_pll_dyn_ctrl: self-checking bench for pll_dyn_ctrl.
// Completion pulses are checked against a queue of expected results.
module tb_pll_dyn_ctrl;

    localparam logic [23:0] IDT = {6'h00, 6'h03, 6'h02, 6'h01};
    localparam logic [23:0] FBT = {6'h00, 6'h2A, 6'h15, 6'h0C};
    localparam logic [23:0] ODT = {6'h00, 6'h38, 6'h3C, 6'h3E};

    localparam logic [5:0] ID0 = 6'h01;
    localparam logic [5:0] ID1 = 6'h02;
    localparam logic [5:0] ID2 = 6'h03;
    localparam logic [5:0] FB0 = 6'h0C;
    localparam logic [5:0] FB2 = 6'h2A;
    localparam logic [5:0] OD0 = 6'h3E;
    localparam logic [5:0] OD2 = 6'h38;

    logic       clkin = 1'b0;
    logic       reset;
    logic       mode_req;
    logic [1:0] mode_sel;
    logic       busy;
    logic       done;
    logic [1:0] status;
    logic [1:0] cur_mode;
    logic       lock_lost;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       rst_out;

    typedef struct {
        logic [1:0] st;
        logic [1:0] md;
    } exp_t;

    exp_t sb_q[$];
    int   n_run  = 0;
    int   n_fail = 0;
    int   n;

    always #5 clkin = ~clkin;

    pll_dyn_ctrl #(
        .NUM_MODES    (3),
        .DEFAULT_MODE (2'd0),
        .IDSEL_TABLE  (IDT),
        .FBDSEL_TABLE (FBT),
        .ODSEL_TABLE  (ODT),
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (100),
        .STABLE_CYCLES(8),
        .MAX_RETRY    (2)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .mode_req  (mode_req),
        .mode_sel  (mode_sel),
        .busy      (busy),
        .done      (done),
        .status    (status),
        .cur_mode  (cur_mode),
        .lock_lost (lock_lost),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .pll_idsel (pll_idsel),
        .pll_fbdsel(pll_fbdsel),
        .pll_odsel (pll_odsel),
        .rst_out   (rst_out)
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] st, input logic [1:0] md);
        exp_t e;
        e.st = st;
        e.md = md;
        sb_q.push_back(e);
    endtask

    task automatic req(input logic [1:0] m);
        mode_req = 1'b1;
        mode_sel = m;
        @(negedge clkin);
        mode_req = 1'b0;
    endtask

    task automatic rst_width(output int w);
        w = 0;
        while (pll_reset && w < 50) begin
            @(negedge clkin);
            w++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clkin);
            k++;
        end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    always @(negedge clkin) begin
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                chk("done_unexp", 32'(done), 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("done_status", 32'(status), 32'(e.st));
                chk("done_mode", 32'(cur_mode), 32'(e.md));
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        pll_lock = 1'b0;
        mode_req = 1'b0;
        mode_sel = 2'd0;
        repeat (3) @(negedge clkin);
        chk("rst_pll_reset", 32'(pll_reset), 1);
        chk("rst_rst_out", 32'(rst_out), 1);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_status", 32'(status), 0);
        chk("rst_lock_lost", 32'(lock_lost), 0);
        chk("rst_cur_mode", 32'(cur_mode), 0);
        chk("rst_idsel", 32'(pll_idsel), 32'(ID0));
        chk("rst_fbdsel", 32'(pll_fbdsel), 32'(FB0));
        chk("rst_odsel", 32'(pll_odsel), 32'(OD0));

        // Boot
        reset = 1'b0;
        rst_width(n);
        chk("boot_rst_w", n, 4);
        repeat (10) @(negedge clkin);
        pll_lock = 1'b1;
        n = 0;
        while (rst_out && n < 300) begin
            @(negedge clkin);
            n++;
        end
        chk("boot_lock2run", n, 10);
        chk("boot_busy", 32'(busy), 0);

        // Mode change to 2
        push(2'd0, 2'd2);
        req(2'd2);
        pll_lock = 1'b0;
        chk("mc_busy", 32'(busy), 1);
        chk("mc_cur_mode", 32'(cur_mode), 2);
        chk("mc_idsel", 32'(pll_idsel), 32'(ID2));
        chk("mc_fbdsel", 32'(pll_fbdsel), 32'(FB2));
        chk("mc_odsel", 32'(pll_odsel), 32'(OD2));
        rst_width(n);
        chk("mc_rst_w", n, 4);
        repeat (5) @(negedge clkin);
        pll_lock = 1'b1;
        wait_idle(200);
        chk("mc_rst_out", 32'(rst_out), 0);

        // Invalid request
        push(2'd1, 2'd2);
        req(2'd3);
        chk("inv_done", 32'(done), 1);
        chk("inv_busy", 32'(busy), 0);
        chk("inv_pll_reset", 32'(pll_reset), 0);
        chk("inv_idsel", 32'(pll_idsel), 32'(ID2));
        @(negedge clkin);
        chk("inv_done_1cyc", 32'(done), 0);
        chk("inv_busy2", 32'(busy), 0);

        // Lock glitch in RUN
        pll_lock = 1'b0;
        repeat (3) @(negedge clkin);
        pll_lock = 1'b1;
        chk("gl_lock_lost", 32'(lock_lost), 1);
        chk("gl_rst_out", 32'(rst_out), 1);
        chk("gl_busy", 32'(busy), 1);
        rst_width(n);
        chk("gl_rst_w", n, 4);
        wait_idle(200);
        chk("gl_sticky", 32'(lock_lost), 1);
        chk("gl_relock", 32'(rst_out), 0);
        chk("gl_mode", 32'(cur_mode), 2);

        // Lock failure to FAIL
        push(2'd2, 2'd1);
        pll_lock = 1'b0;
        req(2'd1);
        chk("lf_lock_lost_clr", 32'(lock_lost), 0);
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clkin);
            n++;
        end
        chk("lf_cycles", n, 312);
        chk("lf_pll_reset", 32'(pll_reset), 1);
        chk("lf_rst_out", 32'(rst_out), 1);
        chk("lf_idsel", 32'(pll_idsel), 32'(ID1));
        repeat (20) @(negedge clkin);
        chk("lf_hold_reset", 32'(pll_reset), 1);
        chk("lf_hold_busy", 32'(busy), 0);

        // Restart from FAIL
        push(2'd0, 2'd0);
        pll_lock = 1'b1;
        req(2'd0);
        chk("rs_busy", 32'(busy), 1);
        wait_idle(300);
        chk("rs_mode", 32'(cur_mode), 0);
        chk("rs_rst_out", 32'(rst_out), 0);
        chk("rs_idsel", 32'(pll_idsel), 32'(ID0));

        // Reset during relock of mode 2
        pll_lock = 1'b0;
        req(2'd2);
        rst_width(n);
        repeat (5) @(negedge clkin);
        chk("mr_pre_mode", 32'(cur_mode), 2);
        chk("mr_pre_busy", 32'(busy), 1);
        chk("mr_pre_preset", 32'(pll_reset), 0);
        reset = 1'b1;
        #1;
        chk("mr_cur_mode", 32'(cur_mode), 0);
        chk("mr_idsel", 32'(pll_idsel), 32'(ID0));
        chk("mr_fbdsel", 32'(pll_fbdsel), 32'(FB0));
        chk("mr_pll_reset", 32'(pll_reset), 1);
        chk("mr_busy", 32'(busy), 1);
        chk("mr_lock_lost", 32'(lock_lost), 0);
        @(negedge clkin);
        reset    = 1'b0;
        pll_lock = 1'b1;
        wait_idle(300);
        chk("mr_reboot", 32'(rst_out), 0);

        repeat (5) @(negedge clkin);
        chk("sb_left", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
